// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - two-to-one round-robin arbiter onto a single SRAM-like memory port
//
// Shares one SRAM-like memory port between the instruction-fetch side and the
// data-access side. Only one transaction is outstanding at a time, and its
// response is routed back to the side that owns it. When both sides request
// in the same cycle, the side that was not granted last time wins.
//
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   inst_* / data_*              per-side request (req/wr/size/addr/wdata) in,
//                                addr_ok/data_ok/rdata out
//   mem_req, mem_wr, mem_size,   registered request to the memory bridge
//   mem_addr, mem_wdata
//   mem_addr_ok, mem_data_ok,    memory handshakes and read data
//   mem_rdata

module sram_like_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t state;
    logic   owner;       // 0 = inst, 1 = data
    logic   last_grant;  // 0 = inst, 1 = data
    logic   grant_data;
    logic   grant_inst;
    logic   accept_ok;
    logic   resp;

    // Data wins unless inst is also requesting and data was the last winner.
    always_comb begin
        grant_data = data_req && (!inst_req || !last_grant);
        grant_inst = inst_req && !grant_data;
    end

    // Gated by resetn so every output reads 0 while reset is held, even if a
    // requester keeps its request up.
    assign accept_ok    = resetn && (state == S_IDLE);
    assign inst_addr_ok = accept_ok && grant_inst;
    assign data_addr_ok = accept_ok && grant_data;

    // mem_data_ok only counts while a transaction is waiting for it.
    assign resp         = resetn && (state == S_WAIT) && mem_data_ok;
    assign inst_data_ok = resp && !owner;
    assign data_data_ok = resp && owner;
    assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
    assign data_rdata   = data_data_ok ? mem_rdata : '0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b0;
            mem_req    <= 1'b0;
            mem_wr     <= 1'b0;
            mem_size   <= 2'd0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_data || grant_inst) begin
                        owner      <= grant_data;
                        last_grant <= grant_data;
                        mem_wr     <= grant_data ? data_wr    : inst_wr;
                        mem_size   <= grant_data ? data_size  : inst_size;
                        mem_addr   <= grant_data ? data_addr  : inst_addr;
                        mem_wdata  <= grant_data ? data_wdata : inst_wdata;
                        mem_req    <= 1'b1;
                        state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_addr_ok) begin
                        mem_req <= 1'b0;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_data_ok) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sram_like_arbiter.md
# sram_like_arbiter

Two-to-one arbiter that shares a single SRAM-like memory port between the CPU's instruction-fetch and data-access paths. It sits between the IF/EXE/MEM stages and the external memory bridge. It accepts one request at a time, keeps exactly one transaction outstanding, and routes each response back to the owner. Grant order is round-robin when both sides request, so a stream of loads/stores cannot starve instruction fetch.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- inst_req / data_req  in  1  request valid, per side
- inst_wr / data_wr  in  1  1 = write, 0 = read
- inst_size / data_size  in  2  0 = byte, 1 = half, 2 = word
- inst_addr / data_addr  in  ADDR_W  request address
- inst_wdata / data_wdata  in  DATA_W  write data
- inst_addr_ok / data_addr_ok  out  1  request accepted this cycle
- inst_data_ok / data_data_ok  out  1  response for this side this cycle
- inst_rdata / data_rdata  out  DATA_W  read data, valid only with the matching data_ok
- mem_req  out  1  request to memory
- mem_wr, mem_size, mem_addr, mem_wdata  out  1/2/ADDR_W/DATA_W  registered request fields
- mem_addr_ok  in  1  memory accepted request
- mem_data_ok  in  1  memory response
- mem_rdata  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, REQ, WAIT. Registers: owner (0 = inst, 1 = data), last_grant, and latched wr/size/addr/wdata.
- IDLE:
  - Only data_req set: grant data.
  - Only inst_req set: grant inst.
  - Both set: grant the side not equal to last_grant.
  - On grant: assert the winner's addr_ok combinationally, latch the winner's fields, set owner and last_grant, go to REQ.
  - The loser's addr_ok stays 0. The loser must hold its request.
- REQ:
  - mem_req = 1, driven from the latched fields.
  - Hold in REQ until mem_addr_ok = 1, then go to WAIT.
  - Fields must not change while in REQ.
- WAIT:
  - mem_req = 0.
  - On mem_data_ok = 1: assert owner's data_ok, drive owner's rdata = mem_rdata, go to IDLE.
- Writes also complete through mem_data_ok. The owner's data_ok fires with rdata = mem_rdata, which is don't-care for writes.
- A side's rdata is 0 whenever its data_ok = 0.
- addr_ok is never asserted outside IDLE. Both addr_ok signals are never high in the same cycle. Both data_ok signals are never high in the same cycle.
- mem_data_ok in IDLE or REQ is ignored and produces no data_ok.
- mem_addr_ok outside REQ is ignored.

## Timing
- Reset values:
  - state = IDLE; last_grant = inst, so data wins the first tie.
  - owner = 0; latched fields = 0.
  - All outputs = 0: mem_req, mem_*, addr_ok, data_ok, rdata.
- Reset asserted mid-transaction: return to IDLE immediately. The in-flight transaction is abandoned and its later mem_data_ok is ignored.
- Minimum latency with mem_addr_ok tied high and data returned the next cycle:
  - cycle 0: addr_ok
  - cycle 1: mem_req and mem_addr_ok
  - cycle 2: mem_data_ok and data_ok
  - cycle 3: IDLE again; the next addr_ok can occur in this cycle.
- Throughput: at most one transaction per 3 cycles. No pipelining across transactions.
- mem_addr_ok stalls extend REQ by one cycle each. mem_data_ok stalls extend WAIT by one cycle each. There is no timeout.
- Round-robin memory is last_grant only. A single requester is always granted on consecutive transactions.

## Test plan
- Single inst read, addr 0xBFC00000, size 2; memory returns 0x3C1D0000 one cycle after addr_ok -> inst_addr_ok at cycle 0, mem_req at cycle 1, inst_data_ok with inst_rdata = 0x3C1D0000 at cycle 2, data_* outputs stay 0.
- Both request in the same cycle after reset (inst 0xBFC00004, data write 0x80001000 / 0xDEADBEEF, size 2) -> data granted first and mem_wr = 1, mem_wdata = 0xDEADBEEF; inst granted next IDLE; two grants in order data, inst.
- Continuous data_req with continuous inst_req over 6 transactions -> grants strictly alternate data, inst, data, inst, data, inst.
- mem_addr_ok held low 4 cycles, then data delayed 3 cycles -> mem_req high for 5 cycles with addr/size/wdata constant; exactly one data_ok; no addr_ok during the stall.
- Byte store data_addr 0x80000003, size 0 -> mem_addr = 0x80000003, mem_size = 0, data_data_ok on mem_data_ok.
- resetn pulled low while in WAIT, released, then a stale mem_data_ok arrives -> all outputs 0 during reset; the stale response produces no data_ok; the next inst request completes normally.
